// File: rtl/taylor_pkg.sv
// Shared definitions for the Taylor-series kernel.
// Optional feature macro: TAYLOR_ROUND_EN (round-half-up in every product term).
package taylor_pkg;

  localparam int MAX_NTERM = 6;
  localparam int MAX_DW    = 16;
  localparam int MAX_IW    = 8;
  localparam int MAX_AW    = MAX_DW + MAX_IW;

  // Default per-term extra shifts: 1/2, 1/3 ~ 1/4, 1/4 ~ 1/2 -> approximates e^t.
  localparam logic [8:0] DEFAULT_TERM_SHIFT = {3'd1, 3'd2, 3'd1};

  // One pipeline stage's state. Sized for the largest supported configuration;
  // bits above the configured widths are always zero.
  typedef struct packed {
    logic              valid;
    logic              sign;
    logic [MAX_DW-1:0] t;
    logic [MAX_AW-1:0] acc;
    logic [MAX_DW-1:0] p;
  } stage_rec_t;

  localparam int PW = 2 * MAX_DW + 1;

  // (t * p) >> (dw + sh), optionally rounded half up. Operands are < 2^dw, so the
  // shifted product (rounded or not) always fits in dw bits.
  function automatic logic [MAX_DW-1:0] mul_shift(input logic [MAX_DW-1:0] t,
                                                  input logic [MAX_DW-1:0] p,
                                                  input int                dw,
                                                  input logic [2:0]        sh);
    logic [PW-1:0] prod;
    int            rsh;
    rsh  = dw + int'(sh);
    prod = PW'(t) * PW'(p);
`ifdef TAYLOR_ROUND_EN
    prod = prod + (PW'(1) << (rsh - 1));
`else
    prod = prod;
`endif
    return MAX_DW'(prod >> rsh);
  endfunction

endpackage

// File: rtl/taylor_stage.sv
// One accumulate (+ optional next-term multiply) stage of the Taylor kernel.
// Stage index K selects the term power K+2; odd powers subtract for negative t.
// Optional feature macro (via taylor_pkg::mul_shift): TAYLOR_ROUND_EN.
module taylor_stage
  import taylor_pkg::*;
#(
  parameter int         DW         = 8,
  parameter int         IW         = 2,
  parameter int         K          = 0,
  parameter int         DO_MUL     = 1,
  parameter logic [2:0] SHIFT_NEXT = 3'd0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  stage_rec_t d,
  output stage_rec_t q
);

  localparam int   AW       = IW + DW;
  localparam logic SUB_TERM = ((K % 2) == 1);

  logic [AW-1:0] acc_in;
  logic [AW-1:0] p_ext;
  logic [AW-1:0] acc_next;
  logic [DW-1:0] p_next;
  stage_rec_t    q_next;
  logic          unused_ok;

  // Accumulate the incoming term and form the next-higher term.
  always_comb begin
    acc_in   = d.acc[AW-1:0];
    p_ext    = AW'(d.p[DW-1:0]);
    acc_next = (d.sign && SUB_TERM) ? (acc_in - p_ext) : (acc_in + p_ext);
    p_next   = '0;
    if (DO_MUL != 0) begin
      p_next = DW'(mul_shift(d.t, d.p, DW, SHIFT_NEXT));
    end
    q_next       = '0;
    q_next.valid = d.valid;
    q_next.sign  = d.sign;
    q_next.t     = d.t;
    q_next.acc   = MAX_AW'(acc_next);
    q_next.p     = MAX_DW'(p_next);
  end

  // Upper record bits are structurally zero and intentionally ignored.
  assign unused_ok = &{1'b0, d};

  // Stage register; frozen while the pipeline is stalled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= '0;
    end else if (en) begin
      q <= q_next;
    end
  end

endmodule

// File: rtl/taylor_kernel_pp.sv
// Pipelined Taylor-series kernel: oData = 1 +/- t + t^2/.. +/- t^3/.. + ...
// Stage 1 (here) seeds the accumulator and the t^2 term; NTERM taylor_stage
// instances add one term each. Single global stall driven by the output side.
// Optional feature macro: TAYLOR_ROUND_EN (round-half-up products).
module taylor_kernel_pp
  import taylor_pkg::*;
#(
  parameter int                 DW         = 8,
  parameter int                 IW         = 2,
  parameter int                 NTERM      = 3,
  parameter logic [NTERM*3-1:0] TERM_SHIFT = DEFAULT_TERM_SHIFT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [DW-1:0]    iData,
  input  logic             iSign,
  input  logic             iValid,
  output logic             oReady,
  output logic [IW+DW-1:0] oData,
  output logic             oValid,
  input  logic             iReady
);

  localparam int            AW  = IW + DW;
  localparam logic [AW-1:0] ONE = AW'(1) << DW;

  if (NTERM < 1 || NTERM > MAX_NTERM || DW > MAX_DW || IW > MAX_IW) begin : g_bad_cfg
    $error("taylor_kernel_pp: unsupported configuration");
  end

  logic       stall;
  logic       en;
  stage_rec_t s1_reg;
  stage_rec_t s1_next;
  stage_rec_t pipe [NTERM+1];
  logic       unused_tail;

  // A held output blocks everything behind it.
  assign stall  = oValid & ~iReady;
  assign oReady = ~stall;
  assign en     = ~stall;

  // Stage 1: 1 +/- t and the first product term t^2 >> shift.
  always_comb begin
    s1_next       = '0;
    s1_next.valid = iValid;
    s1_next.sign  = iSign;
    s1_next.t     = MAX_DW'(iData);
    s1_next.acc   = MAX_AW'(iSign ? (ONE - AW'(iData)) : (ONE + AW'(iData)));
    s1_next.p     = MAX_DW'(DW'(mul_shift(MAX_DW'(iData), MAX_DW'(iData), DW, TERM_SHIFT[2:0])));
  end

  // Stage 1 register; when not stalled a missing iValid loads a bubble.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_reg <= '0;
    end else if (en) begin
      s1_reg <= s1_next;
    end
  end

  assign pipe[0] = s1_reg;

  for (genvar gi = 0; gi < NTERM; gi++) begin : g_stage
    if (gi < NTERM - 1) begin : g_mul
      taylor_stage #(
        .DW        (DW),
        .IW        (IW),
        .K         (gi),
        .DO_MUL    (1),
        .SHIFT_NEXT(TERM_SHIFT[3*(gi+1) +: 3])
      ) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .d    (pipe[gi]),
        .q    (pipe[gi+1])
      );
    end else begin : g_last
      taylor_stage #(
        .DW        (DW),
        .IW        (IW),
        .K         (gi),
        .DO_MUL    (0),
        .SHIFT_NEXT(3'd0)
      ) u_stage (
        .clk  (clk),
        .rst_n(rst_n),
        .en   (en),
        .d    (pipe[gi]),
        .q    (pipe[gi+1])
      );
    end
  end

  // The last stage register is the output register.
  assign oValid = pipe[NTERM].valid;
  assign oData  = pipe[NTERM].acc[AW-1:0];

  assign unused_tail = &{1'b0, pipe[NTERM]};

endmodule

// File: tb/tb_taylor_kernel_pp.sv
// Directed bench for taylor_kernel_pp (DW=8, IW=2, NTERM=3).
// Expected values are hand-computed for both the truncating and TAYLOR_ROUND_EN builds.
module tb_taylor_kernel_pp;

  logic       clk;
  logic       rst_n;
  logic [7:0] iData;
  logic       iSign;
  logic       iValid;
  logic       oReady;
  logic [9:0] oData;
  logic       oValid;
  logic       iReady;

  int vectors    = 0;
  int miscompares = 0;

  logic       collect = 1'b0;
  logic [9:0] got_q [$];

  taylor_kernel_pp dut (
    .clk   (clk),
    .rst_n (rst_n),
    .iData (iData),
    .iSign (iSign),
    .iValid(iValid),
    .oReady(oReady),
    .oData (oData),
    .oValid(oValid),
    .iReady(iReady)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every consumed output while collection is enabled.
  always @(negedge clk) begin
    if (collect && rst_n && oValid && iReady) got_q.push_back(oData);
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One isolated sample: checks latency, value and single-cycle oValid pulse.
  task automatic run_single(input int t, input int s, input int exp, input string tag);
    iData  = 8'(t);
    iSign  = s[0];
    iValid = 1'b1;
    tick();
    iValid = 1'b0;
    tick();
    tick();
    check({tag, "_lat"}, 32'(oValid), 32'd0);
    tick();
    check({tag, "_valid"}, 32'(oValid), 32'd1);
    check({tag, "_data"}, 32'(oData), 32'(exp));
    tick();
    check({tag, "_pulse"}, 32'(oValid), 32'd0);
  endtask

  initial begin
    int   str_t   [8];
    int   str_s   [8];
    int   str_exp [8];
    int   exp_255;
    int   exp_200;
    int   idx;
    logic acc_now;
    logic [31:0] got;

    str_t = '{0, 128, 128, 64, 64, 200, 200, 255};
    str_s = '{0, 0,   1,   0,  1,  0,   1,   0};
`ifdef TAYLOR_ROUND_EN
    str_exp = '{256, 421, 157, 329, 199, 555, 125, 686};
    exp_255 = 686;
    exp_200 = 555;
`else
    str_exp = '{256, 421, 157, 328, 200, 554, 124, 684};
    exp_255 = 684;
    exp_200 = 554;
`endif

    // Reset state
    rst_n  = 1'b0;
    iValid = 1'b0;
    iData  = '0;
    iSign  = 1'b0;
    iReady = 1'b1;
    #12;
    check("rst_ovalid", 32'(oValid), 32'd0);
    check("rst_odata", 32'(oData), 32'd0);
    check("rst_oready", 32'(oReady), 32'd1);
    tick();
    rst_n = 1'b1;
    tick();

    // Isolated samples
    run_single(128, 0, 421, "t128_pos");
    run_single(128, 1, 157, "t128_neg");
    run_single(0, 0, 256, "t0_pos");
    run_single(0, 1, 256, "t0_neg");
    run_single(255, 0, exp_255, "t255_pos");

    // Back-to-back stream with a 3-cycle downstream stall
    got_q.delete();
    collect = 1'b1;
    idx = 0;
    for (int c = 0; c < 30; c++) begin
      iReady = !(c >= 6 && c <= 8);
      iValid = (idx < 8);
      iData  = (idx < 8) ? 8'(str_t[idx]) : 8'd0;
      iSign  = (idx < 8) ? str_s[idx][0] : 1'b0;
      #1;
      if (c == 5) check("pre_stall_ready", 32'(oReady), 32'd1);
      if (c >= 6 && c <= 8) begin
        check($sformatf("stall_ready_%0d", c), 32'(oReady), 32'd0);
        check($sformatf("stall_valid_%0d", c), 32'(oValid), 32'd1);
        check($sformatf("stall_data_%0d", c), 32'(oData), 32'd157);
      end
      acc_now = iValid && oReady;
      @(posedge clk);
      #1;
      if (acc_now) idx++;
    end
    iValid  = 1'b0;
    iReady  = 1'b1;
    collect = 1'b0;
    check("stream_count", 32'(got_q.size()), 32'd8);
    for (int k = 0; k < 8; k++) begin
      got = (k < got_q.size()) ? 32'(got_q[k]) : 'x;
      check($sformatf("stream_%0d", k), got, 32'(str_exp[k]));
    end

    // iValid every other cycle: oValid follows 4 cycles later
    for (int c = 0; c < 14; c++) begin
      iValid = (c < 8) && (c % 2 == 0);
      iData  = 8'd128;
      iSign  = 1'b0;
      #1;
      if (c >= 4 && c < 12 && ((c - 4) % 2 == 0)) begin
        check($sformatf("toggle_valid_%0d", c), 32'(oValid), 32'd1);
        check($sformatf("toggle_data_%0d", c), 32'(oData), 32'd421);
      end else begin
        check($sformatf("toggle_valid_%0d", c), 32'(oValid), 32'd0);
      end
      @(posedge clk);
      #1;
    end
    iValid = 1'b0;

    // Reset with samples in flight
    for (int c = 0; c < 3; c++) begin
      iValid = 1'b1;
      iData  = 8'd128;
      iSign  = 1'b0;
      tick();
    end
    iValid = 1'b0;
    tick();
    check("inflight_valid", 32'(oValid), 32'd1);
    check("inflight_data", 32'(oData), 32'd421);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_valid", 32'(oValid), 32'd0);
    check("async_rst_data", 32'(oData), 32'd0);
    tick();
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 6; c++) begin
      tick();
      check($sformatf("post_rst_idle_%0d", c), 32'(oValid), 32'd0);
    end
    run_single(200, 0, exp_200, "post_rst_t200");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
